// File: rtl/hmac_msg_packer.sv
// hmac_msg_packer: write side of the SHA-256 message FIFO.
// Compacts byte-masked 32-bit writes into whole words, first byte in [31:24].
// Tracks the message bit length and emits an MSB-aligned partial word on flush.
module hmac_msg_packer #(
   parameter int unsigned MsgLenW = 64,
   parameter int unsigned NumLane = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sha_en_i,
   input  logic                 endian_swap_i,
   input  logic                 hash_start_i,
   input  logic                 flush_i,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [31:0]          wr_data_i,
   input  logic [NumLane-1:0]   wr_mask_i,
   output logic                 fifo_valid_o,
   input  logic                 fifo_ready_i,
   output logic [31:0]          fifo_data_o,
   output logic [NumLane-1:0]   fifo_mask_o,
   output logic [MsgLenW-1:0]   msg_len_o,
   output logic                 flush_done_o,
   output logic                 msg_drop_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           acc_q [7];
   logic [7:0]           acc_d [7];
   logic [2:0]           acc_cnt_q, acc_cnt_d;
   logic [31:0]          out_data_q, out_data_d;
   logic [NumLane-1:0]   out_mask_q, out_mask_d;
   logic                 out_valid_q, out_valid_d;
   logic [MsgLenW-1:0]   msg_len_q, msg_len_d;
   logic                 msg_drop_q, msg_drop_d;

   // control decodes produced by the FSM output process
   logic                 sink;
   logic                 out_free;
   logic                 hs_act;
   logic                 drain;
   logic                 partial;
   logic                 flush_done;
   logic                 wr_ready;
   logic                 wr_accept;

   // datapath scratch
   logic [7:0]           lane_b [NumLane];
   logic [NumLane-1:0]   lane_v;
   logic [7:0]           rem [7];
   logic [2:0]           rem_cnt;
   logic [2:0]           pos;
   logic [2:0]           nbytes;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   // Next-state logic: disable dominates, flush only taken from ACTIVE.
   always_comb begin
      state_d = state_q;
      if (!sha_en_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:   state_d = ST_ACTIVE;
            ST_ACTIVE: if (flush_i) state_d = ST_FLUSH;
            ST_FLUSH:  if (flush_done) state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: handshake, drain/partial decisions and the flush-done pulse.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      sink       = !sha_en_i || (state_q == ST_IDLE);
      out_free   = !out_valid_q || fifo_ready_i;
      hs_act     = sha_en_i && (state_q == ST_ACTIVE) && hash_start_i;
      drain      = 1'b0;
      partial    = 1'b0;
      flush_done = 1'b0;
      wr_ready   = 1'b0;
      if (!sink) begin
         drain = !hs_act && (acc_cnt_q >= 3'd4) && out_free;
         if (state_q == ST_FLUSH) begin
            partial    = (acc_cnt_q != 3'd0) && (acc_cnt_q < 3'd4) && out_free;
            flush_done = (acc_cnt_q == 3'd0) && out_free;
         end else begin
            wr_ready = (acc_cnt_q < 3'd4) || drain;
         end
      end else begin
         wr_ready = 1'b1;
      end
      wr_accept = wr_valid_i && wr_ready && !sink && !hs_act;
   end

   // Datapath: drain or partial load, then append the newly accepted bytes.
   always_comb begin
      out_data_d  = out_data_q;
      out_mask_d  = out_mask_q;
      out_valid_d = out_valid_q;
      msg_len_d   = msg_len_q;
      msg_drop_d  = sink && wr_valid_i;
      rem         = acc_q;
      rem_cnt     = acc_cnt_q;
      nbytes      = 3'd0;

      // the output word leaves on the handshake; idle output reads as zero
      if (fifo_ready_i) begin
         out_valid_d = 1'b0;
         out_data_d  = 32'h0;
         out_mask_d  = '0;
      end

      if (drain) begin
         out_data_d  = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
         out_mask_d  = '1;
         out_valid_d = 1'b1;
         for (int k = 0; k < 3; k++) begin
            rem[k] = acc_q[k+4];
         end
         rem_cnt = acc_cnt_q - 3'd4;
      end else if (partial) begin
         out_data_d  = {acc_q[0],
                        (acc_cnt_q >= 3'd2) ? acc_q[1] : 8'h00,
                        (acc_cnt_q == 3'd3) ? acc_q[2] : 8'h00,
                        8'h00};
         unique case (acc_cnt_q)
            3'd1:    out_mask_d = 4'b1000;
            3'd2:    out_mask_d = 4'b1100;
            default: out_mask_d = 4'b1110;
         endcase
         out_valid_d = 1'b1;
         rem_cnt     = 3'd0;
      end

      // lane reordering puts the first byte of the write at index 0
      for (int i = 0; i < NumLane; i++) begin
         if (endian_swap_i) begin
            lane_b[i] = wr_data_i[8*(NumLane-1-i) +: 8];
            lane_v[i] = wr_mask_i[NumLane-1-i];
         end else begin
            lane_b[i] = wr_data_i[8*i +: 8];
            lane_v[i] = wr_mask_i[i];
         end
      end

      pos = rem_cnt;
      if (wr_accept) begin
         for (int i = 0; i < NumLane; i++) begin
            if (lane_v[i]) begin
               rem[pos] = lane_b[i];
               pos      = pos + 3'd1;
               nbytes   = nbytes + 3'd1;
            end
         end
         msg_len_d = msg_len_q + {{(MsgLenW-6){1'b0}}, nbytes, 3'b000};
      end

      acc_d     = rem;
      acc_cnt_d = pos;

      if (hs_act) begin
         acc_cnt_d = 3'd0;
         msg_len_d = '0;
      end

      if (sink) begin
         acc_cnt_d   = 3'd0;
         out_valid_d = 1'b0;
         out_data_d  = 32'h0;
         out_mask_d  = '0;
         msg_len_d   = '0;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_cnt_q   <= 3'd0;
         out_data_q  <= 32'h0;
         out_mask_q  <= '0;
         out_valid_q <= 1'b0;
         msg_len_q   <= '0;
         msg_drop_q  <= 1'b0;
      end else begin
         acc_cnt_q   <= acc_cnt_d;
         out_data_q  <= out_data_d;
         out_mask_q  <= out_mask_d;
         out_valid_q <= out_valid_d;
         msg_len_q   <= msg_len_d;
         msg_drop_q  <= msg_drop_d;
      end
   end

   // Accumulator byte storage.
   always_ff @(posedge clk_i) begin
      // NOTE: byte storage is not reset; acc_cnt_q alone says which bytes are meaningful.
      acc_q <= acc_d;
   end

   assign wr_ready_o   = wr_ready;
   assign fifo_valid_o = out_valid_q;
   assign fifo_data_o  = out_data_q;
   assign fifo_mask_o  = out_mask_q;
   assign msg_len_o    = msg_len_q;
   assign flush_done_o = flush_done;
   assign msg_drop_o   = msg_drop_q;

endmodule

// File: tb/tb_hmac_msg_packer.sv
// Directed bench for hmac_msg_packer: a per-cycle vector table plus hand-built
// sequences for backpressure, disable during flush and hash restart.
module tb_hmac_msg_packer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        sha_en_i, endian_swap_i, hash_start_i, flush_i;
   logic        wr_valid_i, wr_ready_o;
   logic [31:0] wr_data_i;
   logic [3:0]  wr_mask_i;
   logic        fifo_valid_o, fifo_ready_i;
   logic [31:0] fifo_data_o;
   logic [3:0]  fifo_mask_o;
   logic [63:0] msg_len_o;
   logic        flush_done_o, msg_drop_o;

   int total  = 0;
   int passed = 0;

   hmac_msg_packer dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .sha_en_i      (sha_en_i),
      .endian_swap_i (endian_swap_i),
      .hash_start_i  (hash_start_i),
      .flush_i       (flush_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ready_o    (wr_ready_o),
      .wr_data_i     (wr_data_i),
      .wr_mask_i     (wr_mask_i),
      .fifo_valid_o  (fifo_valid_o),
      .fifo_ready_i  (fifo_ready_i),
      .fifo_data_o   (fifo_data_o),
      .fifo_mask_o   (fifo_mask_o),
      .msg_len_o     (msg_len_o),
      .flush_done_o  (flush_done_o),
      .msg_drop_o    (msg_drop_o)
   );

   always #5 clk_i = ~clk_i;

   // inputs for one cycle and the outputs expected during that cycle
   typedef struct {
      logic        sha_en, swap, hs, flush, wr_valid;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        fifo_ready;
      logic        e_ready, e_valid;
      logic [31:0] e_data;
      logic [3:0]  e_mask;
      logic [63:0] e_len;
      logic        e_done, e_drop;
   } vec_t;

   function automatic vec_t mk(input logic sha_en, swap, hs, flush, wr_valid,
                               input logic [31:0] data, input logic [3:0] mask,
                               input logic fifo_ready, e_ready, e_valid,
                               input logic [31:0] e_data, input logic [3:0] e_mask,
                               input logic [63:0] e_len, input logic e_done, e_drop);
      vec_t v;
      v.sha_en = sha_en; v.swap = swap; v.hs = hs; v.flush = flush; v.wr_valid = wr_valid;
      v.data = data; v.mask = mask; v.fifo_ready = fifo_ready;
      v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data; v.e_mask = e_mask;
      v.e_len = e_len; v.e_done = e_done; v.e_drop = e_drop;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   // drive one cycle: inputs applied just after posedge, outputs sampled at negedge
   task automatic run_vec(input vec_t v, input string tag);
      sha_en_i      = v.sha_en;
      endian_swap_i = v.swap;
      hash_start_i  = v.hs;
      flush_i       = v.flush;
      wr_valid_i    = v.wr_valid;
      wr_data_i     = v.data;
      wr_mask_i     = v.mask;
      fifo_ready_i  = v.fifo_ready;
      @(negedge clk_i);
      check({tag, ".wr_ready"},   {63'd0, wr_ready_o},   {63'd0, v.e_ready});
      check({tag, ".fifo_valid"}, {63'd0, fifo_valid_o}, {63'd0, v.e_valid});
      check({tag, ".fifo_data"},  {32'd0, fifo_data_o},  {32'd0, v.e_data});
      check({tag, ".fifo_mask"},  {60'd0, fifo_mask_o},  {60'd0, v.e_mask});
      check({tag, ".msg_len"},    msg_len_o,             v.e_len);
      check({tag, ".flush_done"}, {63'd0, flush_done_o}, {63'd0, v.e_done});
      check({tag, ".msg_drop"},   {63'd0, msg_drop_o},   {63'd0, v.e_drop});
      @(posedge clk_i);
      #1;
   endtask

   vec_t tbl [19];

   initial begin
      rst_i = 1'b1;
      sha_en_i = 0; endian_swap_i = 0; hash_start_i = 0; flush_i = 0;
      wr_valid_i = 0; wr_data_i = 0; wr_mask_i = 0; fifo_ready_i = 0;

      // streaming writes, partial flush, swapped lanes; fifo always ready
      tbl[0]  = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0);
      tbl[1]  = mk(1,0,0,0,1, 32'h03020100, 4'hF, 1,  1,0,32'h0,        4'h0, 0,  0,0);
      tbl[2]  = mk(1,0,0,0,1, 32'h07060504, 4'hF, 1,  1,0,32'h0,        4'h0, 32, 0,0);
      tbl[3]  = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,1,32'h00010203, 4'hF, 64, 0,0);
      tbl[4]  = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,1,32'h04050607, 4'hF, 64, 0,0);
      tbl[5]  = mk(1,0,1,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 64, 0,0);
      tbl[6]  = mk(1,0,0,0,1, 32'h000000AA, 4'h1, 1,  1,0,32'h0,        4'h0, 0,  0,0);
      tbl[7]  = mk(1,0,0,0,1, 32'h00BBCC00, 4'h6, 1,  1,0,32'h0,        4'h0, 8,  0,0);
      tbl[8]  = mk(1,0,0,1,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 24, 0,0);
      tbl[9]  = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  0,0,32'h0,        4'h0, 24, 0,0);
      tbl[10] = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  0,1,32'hAACCBB00, 4'hE, 24, 1,0);
      tbl[11] = mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 24, 0,0);
      tbl[12] = mk(1,1,1,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 24, 0,0);
      tbl[13] = mk(1,1,0,0,1, 32'h11223344, 4'hF, 1,  1,0,32'h0,        4'h0, 0,  0,0);
      tbl[14] = mk(1,1,0,0,1, 32'h11AABBCC, 4'h8, 1,  1,0,32'h0,        4'h0, 32, 0,0);
      tbl[15] = mk(1,1,0,1,0, 32'h0,        4'h0, 1,  1,1,32'h11223344, 4'hF, 40, 0,0);
      tbl[16] = mk(1,1,0,0,0, 32'h0,        4'h0, 1,  0,0,32'h0,        4'h0, 40, 0,0);
      tbl[17] = mk(1,1,0,0,0, 32'h0,        4'h0, 1,  0,1,32'h11000000, 4'h8, 40, 1,0);
      tbl[18] = mk(1,1,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 40, 0,0);

      // reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst.fifo_valid", {63'd0, fifo_valid_o}, 64'd0);
      check("rst.fifo_data",  {32'd0, fifo_data_o},  64'd0);
      check("rst.fifo_mask",  {60'd0, fifo_mask_o},  64'd0);
      check("rst.msg_len",    msg_len_o,             64'd0);
      check("rst.flush_done", {63'd0, flush_done_o}, 64'd0);
      check("rst.msg_drop",   {63'd0, msg_drop_o},   64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // backpressure: first word held, second in accumulator, third write stalled
      run_vec(mk(1,0,1,0,0, 32'h0,        4'h0, 0,  1,0,32'h0,        4'h0, 40, 0,0), "bp0");
      run_vec(mk(1,0,0,0,1, 32'h03020100, 4'hF, 0,  1,0,32'h0,        4'h0, 0,  0,0), "bp1");
      run_vec(mk(1,0,0,0,1, 32'h07060504, 4'hF, 0,  1,0,32'h0,        4'h0, 32, 0,0), "bp2");
      run_vec(mk(1,0,0,0,1, 32'h0B0A0908, 4'hF, 0,  0,1,32'h00010203, 4'hF, 64, 0,0), "bp3");
      run_vec(mk(1,0,0,0,1, 32'h0B0A0908, 4'hF, 0,  0,1,32'h00010203, 4'hF, 64, 0,0), "bp4");
      run_vec(mk(1,0,0,0,1, 32'h0B0A0908, 4'hF, 1,  1,1,32'h00010203, 4'hF, 64, 0,0), "bp5");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,1,32'h04050607, 4'hF, 96, 0,0), "bp6");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,1,32'h08090A0B, 4'hF, 96, 0,0), "bp7");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 96, 0,0), "bp8");

      // disable while a partial word is held during flush, then a sunk write
      run_vec(mk(1,0,1,0,0, 32'h0,        4'h0, 0,  1,0,32'h0,        4'h0, 96, 0,0), "dis0");
      run_vec(mk(1,0,0,0,1, 32'h0000BBAA, 4'h3, 0,  1,0,32'h0,        4'h0, 0,  0,0), "dis1");
      run_vec(mk(1,0,0,1,0, 32'h0,        4'h0, 0,  1,0,32'h0,        4'h0, 16, 0,0), "dis2");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 0,  0,0,32'h0,        4'h0, 16, 0,0), "dis3");
      run_vec(mk(0,0,0,0,0, 32'h0,        4'h0, 0,  1,1,32'hAABB0000, 4'hC, 16, 0,0), "dis4");
      run_vec(mk(0,0,0,0,1, 32'hDEADBEEF, 4'hF, 0,  1,0,32'h0,        4'h0, 0,  0,0), "dis5");
      run_vec(mk(0,0,0,0,0, 32'h0,        4'h0, 0,  1,0,32'h0,        4'h0, 0,  0,1), "dis6");
      run_vec(mk(0,0,0,0,0, 32'h0,        4'h0, 0,  1,0,32'h0,        4'h0, 0,  0,0), "dis7");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0), "dis8");

      // restart after a 5-byte stream, empty flush, zero mask, start overriding a write
      run_vec(mk(1,0,0,0,1, 32'h44332211, 4'hF, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs0");
      run_vec(mk(1,0,0,0,1, 32'h00000055, 4'h1, 1,  1,0,32'h0,        4'h0, 32, 0,0), "hs1");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,1,32'h11223344, 4'hF, 40, 0,0), "hs2");
      run_vec(mk(1,0,1,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 40, 0,0), "hs3");
      run_vec(mk(1,0,0,1,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs4");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  0,0,32'h0,        4'h0, 0,  1,0), "hs5");
      run_vec(mk(1,0,0,0,1, 32'h12345678, 4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs6");
      run_vec(mk(1,0,1,0,1, 32'h12345678, 4'hF, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs7");
      run_vec(mk(1,0,0,1,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs8");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  0,0,32'h0,        4'h0, 0,  1,0), "hs9");
      run_vec(mk(1,0,0,0,0, 32'h0,        4'h0, 1,  1,0,32'h0,        4'h0, 0,  0,0), "hs10");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
